raster_capture: RTL
===================

# raster_capture

Receive-side counterpart of the raster scan generator. It consumes a pixel stream in raster order (left-to-right, top-to-bottom, default 12×8 grid) and rebuilds the x/y position of each pixel. It checks line and frame framing and stores one complete frame in an internal buffer. Downstream logic reads the buffer back by coordinate once `frame_valid` is high.

## Interface
Parameters:
- `WIDTH`, 12: pixels per line; legal range 2..16.
- `HEIGHT`, 8: lines per frame; legal range 1..16.
- `PIX_W`, 8: pixel data width.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: the input pixel is present this cycle. The block is always ready; there is no backpressure.
- `in_sof` in 1: start of frame; qualifies the pixel at (0,0).
- `in_eol` in 1: end of line; qualifies the pixel at x = WIDTH-1.
- `in_pixel` in PIX_W: pixel data.
- `x` out 4: column of the next expected pixel.
- `y` out 4: row of the next expected pixel.
- `frame_done` out 1: one-cycle pulse when a frame completes.
- `frame_valid` out 1: the buffer holds a complete frame.
- `err` out 1: one-cycle pulse on a framing error.
- `err_code` out 2: cause of the last error; holds until the next error.
- `rd_x` in 4, `rd_y` in 4: readback coordinate.
- `rd_data` out PIX_W: registered readback data.

## Operation
- States: IDLE and CAPTURE.
- Reset values:
  - State is IDLE.
  - `x`, `y`, `frame_done`, `frame_valid`, `err`, `err_code` and `rd_data` are all 0.
  - Buffer contents are undefined and are not reset.
- IDLE:
  - `in_valid` without `in_sof`: the pixel is discarded silently, with no error and no write.
  - `in_valid` with `in_sof`: the pixel is written at (0,0), `frame_valid` is cleared, `x` becomes 1, `y` becomes 0, and the state moves to CAPTURE.
  - If that first pixel also has `in_eol` set, it is an EOL_EARLY error and the state stays IDLE.
- CAPTURE, on each `in_valid` pixel, checked in this priority order:
  1. `in_sof` set: SOF_EARLY error. The frame restarts exactly as the IDLE sof case, with this pixel written at (0,0).
  2. `in_eol` set while `x` < WIDTH-1: EOL_EARLY error. No write; go to IDLE with x = y = 0.
  3. `in_eol` clear while `x` = WIDTH-1: EOL_MISSING error. No write; go to IDLE with x = y = 0.
  4. Otherwise the pixel is written at (`x`,`y`) and the position advances:
     - `x` wraps from WIDTH-1 to 0 and increments `y`.
     - At (WIDTH-1, HEIGHT-1): pulse `frame_done`, set `frame_valid`, go to IDLE with x = y = 0.
- `err_code` values: 0 NONE, 1 SOF_EARLY, 2 EOL_EARLY, 3 EOL_MISSING.
- An aborted frame leaves `frame_valid` at 0 until the next complete frame.
- Cycles with `in_valid` low are ignored in every state; the position holds.
- Buffer address is `y`*WIDTH + `x`. Address arithmetic is unsigned and 8 bits wide; no product exceeds 255.
- Readback:
  - `rd_data` returns the word at (`rd_x`,`rd_y`).
  - Coordinates with `rd_x` ≥ WIDTH or `rd_y` ≥ HEIGHT return 0.
  - A read and a write to the same address in the same cycle returns the old data.
- Reset asserted mid-frame discards the partial frame immediately, without an `err` pulse.

## Timing
- Pixels are accepted at up to one per cycle, back-to-back.
- `x`, `y`, `frame_valid` and `err_code` update on the edge that accepts the pixel.
- `frame_done` and `err` are high for exactly the one cycle after the accepting edge.
- Readback latency is 1 cycle: `rd_x`/`rd_y` are sampled at edge N and `rd_data` is valid after edge N.
- A pixel written at edge N is readable with coordinates presented at edge N+1 or later.

## Structure
- Shared package `raster_pkg`:
  - Default WIDTH/HEIGHT constants, shared with the scan generator.
  - `state_t` enum (IDLE, CAPTURE).
  - `err_code_t` enum.
- Sub-module `raster_frame_mem`: a WIDTH*HEIGHT × PIX_W array with one synchronous write port and one registered read port.
- The framing FSM and position counters live in the top level.

## Test plan
- Clean frame: sof on pixel 0, eol every 12th pixel, 96 back-to-back pixels with value = index. Required: `frame_done` pulses once after pixel 95, `frame_valid` = 1, and reading (5,3) returns 41.
- Gaps: the same frame with `in_valid` low on random cycles. Required: identical buffer contents, and `x`/`y` hold through the gaps.
- EOL_EARLY: eol on pixel (7,2). Required: `err` pulse, `err_code` = 2, state returns to IDLE, `frame_valid` = 0, and non-sof pixels afterwards are ignored.
- EOL_MISSING: pixel (11,0) sent without eol. Required: `err_code` = 3 and `x` = `y` = 0. A following clean frame then completes normally.
- SOF_EARLY: sof on what would be pixel (4,1). Required: `err_code` = 1, `x` = 1, `y` = 0, and the remaining 95 pixels complete the frame.
- Reset at pixel 50, then a clean frame. Required: all outputs are 0 during reset, and the frame completes with no `err`.

Source files
------------

// File: rtl/raster_pkg.sv
// raster_pkg: shared raster grid defaults, capture FSM state and framing error codes
package raster_pkg;
  localparam int DEF_WIDTH = 12;
  localparam int DEF_HEIGHT = 8;
  typedef enum logic {IDLE, CAPTURE} state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_SOF_EARLY, ERR_EOL_EARLY, ERR_EOL_MISSING} err_code_t;
endpackage

// File: rtl/raster_frame_mem.sv
// raster_frame_mem: DEPTH x PIX_W frame buffer; clk/reset, sync write (we/waddr/wdata), registered read (rd_ok/raddr -> rdata, 0 when !rd_ok)
module raster_frame_mem #(
  parameter int DEPTH = 96,
  parameter int PIX_W = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic             rd_ok,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);
  logic [PIX_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or posedge reset)
    if (reset) rdata <= '0;
    else rdata <= rd_ok ? mem[raddr] : '0;
endmodule

// File: rtl/raster_capture.sv
// raster_capture: rebuilds x/y of a raster pixel stream (in_valid/in_sof/in_eol/in_pixel), checks framing (err/err_code), flags frame_done/frame_valid, stores the frame for readback (rd_x/rd_y -> rd_data)
module raster_capture
  import raster_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             in_eol,
  input  logic [PIX_W-1:0] in_pixel,
  output logic [3:0]       x,
  output logic [3:0]       y,
  output logic             frame_done,
  output logic             frame_valid,
  output logic             err,
  output logic [1:0]       err_code,
  input  logic [3:0]       rd_x,
  input  logic [3:0]       rd_y,
  output logic [PIX_W-1:0] rd_data
);
  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] WA = AW'(WIDTH);
  localparam logic [3:0] XL = 4'(WIDTH - 1);
  localparam logic [3:0] YL = 4'(HEIGHT - 1);
  localparam logic [4:0] W5 = 5'(WIDTH);
  localparam logic [4:0] H5 = 5'(HEIGHT);
  state_t state;
  logic x_last, y_last, we, rd_ok;
  logic [AW-1:0] waddr, raddr;
  always_comb begin
    x_last = x == XL;
    y_last = y == YL;
    we = in_valid && (in_sof || (state == CAPTURE && in_eol == x_last));
    waddr = in_sof ? '0 : AW'(y) * WA + AW'(x);
    rd_ok = {1'b0, rd_x} < W5 && {1'b0, rd_y} < H5;
    raddr = AW'(rd_y) * WA + AW'(rd_x);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      frame_done <= 1'b0;
      frame_valid <= 1'b0;
      err <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      frame_done <= 1'b0;
      err <= 1'b0;
      if (in_valid && in_sof) begin
        frame_valid <= 1'b0;
        y <= '0;
        x <= in_eol ? 4'd0 : 4'd1;
        state <= in_eol ? IDLE : CAPTURE;
        err <= in_eol || state == CAPTURE;
        if (in_eol || state == CAPTURE) err_code <= state == CAPTURE ? ERR_SOF_EARLY : ERR_EOL_EARLY;
      end else if (in_valid && state == CAPTURE) begin
        if (in_eol != x_last) begin
          err <= 1'b1;
          err_code <= in_eol ? ERR_EOL_EARLY : ERR_EOL_MISSING;
          state <= IDLE;
          x <= '0;
          y <= '0;
        end else if (!x_last) begin
          x <= x + 4'd1;
        end else begin
          x <= '0;
          y <= y_last ? 4'd0 : y + 4'd1;
          frame_done <= y_last;
          frame_valid <= y_last;
          state <= y_last ? IDLE : CAPTURE;
        end
      end
    end
  raster_frame_mem #(.DEPTH(DEPTH), .PIX_W(PIX_W), .AW(AW)) u_mem (
    .clk(clk),
    .reset(reset),
    .we(we),
    .waddr(waddr),
    .wdata(in_pixel),
    .rd_ok(rd_ok),
    .raddr(raddr),
    .rdata(rd_data)
  );
endmodule
